// File: rtl/midi_cc_source.sv
// midi_cc_source
//   Debounces NUM_BTNS raw push-buttons and emits one 3-byte MIDI Control
//   Change message (status, CC number, value) for each debounced press or
//   release. Bytes are presented on a valid/ready stream for the downstream
//   MIDI UART serialiser.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   btn        raw asynchronous buttons, active-high
//   tx_data    current MIDI byte
//   tx_valid   tx_data is valid
//   tx_ready   downstream accepts the byte this cycle
//   tx_first   high while tx_data is the status byte of a message
//   busy       a message is in flight
//   overrun    one-cycle pulse when a pending button event is overwritten
//   btn_state  debounced button levels
module midi_cc_source #(
  parameter int          NUM_BTNS     = 4,
  parameter int          DEBOUNCE_CNT = 1000000,
  parameter logic [3:0]  CHANNEL      = 4'h0,
  parameter logic [7:0]  FIRST_CC     = 8'd46,
  parameter logic [7:0]  CC_ON_VALUE  = 8'd127,
  parameter logic [7:0]  CC_OFF_VALUE = 8'd0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                tx_first,
  output logic                busy,
  output logic                overrun,
  output logic [NUM_BTNS-1:0] btn_state
);

  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam int SW = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);
  localparam logic [7:0]    STATUS_BYTE = {4'hB, CHANNEL};

  typedef enum logic [1:0] {
    IDLE,
    STATUS,
    DATA1,
    DATA2
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------
  logic [NUM_BTNS-1:0] sync1;
  logic [NUM_BTNS-1:0] sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------------
  // Debounce: a counter per button runs while the synced level disagrees
  // with the debounced level; DEBOUNCE_CNT consecutive disagreeing cycles
  // flip the debounced level.
  // ---------------------------------------------------------------------
  logic [CW-1:0]       cnt [NUM_BTNS];
  logic [NUM_BTNS-1:0] tog;

  always_comb begin
    tog = '0;
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      tog[i] = (sync2[i] != btn_state[i]) && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_BTNS; i++) begin
        cnt[i] <= '0;
      end
      btn_state <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BTNS; i++) begin
        if ((sync2[i] == btn_state[i]) || tog[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      btn_state <= btn_state ^ tog;
    end
  end

  // ---------------------------------------------------------------------
  // Event capture. pend/pend_val hold one outstanding event per button.
  // A toggle in the same edge as the FSM taking that button re-arms pend
  // (set beats clear); that is not an overrun because the old value has
  // already been latched into the outgoing message.
  // ---------------------------------------------------------------------
  logic [NUM_BTNS-1:0] pend;
  logic [NUM_BTNS-1:0] pend_val;
  logic [NUM_BTNS-1:0] clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      pend_val <= '0;
      overrun  <= 1'b0;
    end else begin
      pend     <= (pend & ~clr) | tog;
      pend_val <= (pend_val & ~tog) | (~btn_state & tog);
      overrun  <= |(tog & pend & ~clr);
    end
  end

  // ---------------------------------------------------------------------
  // Message FSM. All stream outputs are registered; the combinational
  // process computes their next values alongside the next state.
  // ---------------------------------------------------------------------
  state_t          state;
  state_t          state_n;
  logic [SW-1:0]   sel;
  logic [SW-1:0]   sel_n;
  logic            val;
  logic            val_n;
  logic [SW-1:0]   pick;
  logic [7:0]      data_n;
  logic            valid_n;
  logic            first_n;
  logic            busy_n;

  // Lowest pending index wins: scan downwards so the last hit is the lowest.
  always_comb begin
    pick = '0;
    for (int unsigned i = NUM_BTNS; i > 0; i--) begin
      if (pend[i-1]) begin
        pick = SW'(i - 1);
      end
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    val_n   = val;
    data_n  = tx_data;
    valid_n = tx_valid;
    first_n = tx_first;
    clr     = '0;

    case (state)
      IDLE: begin
        if (|pend) begin
          sel_n   = pick;
          val_n   = pend_val[pick];
          clr     = NUM_BTNS'(1) << pick;
          data_n  = STATUS_BYTE;
          valid_n = 1'b1;
          first_n = 1'b1;
          state_n = STATUS;
        end
      end
      STATUS: begin
        if (tx_valid && tx_ready) begin
          data_n  = (FIRST_CC + 8'(sel)) & 8'h7F;
          first_n = 1'b0;
          state_n = DATA1;
        end
      end
      DATA1: begin
        if (tx_valid && tx_ready) begin
          data_n  = val ? CC_ON_VALUE : CC_OFF_VALUE;
          state_n = DATA2;
        end
      end
      DATA2: begin
        if (tx_valid && tx_ready) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        valid_n = 1'b0;
        first_n = 1'b0;
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      val      <= 1'b0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_first <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      val      <= val_n;
      tx_data  <= data_n;
      tx_valid <= valid_n;
      tx_first <= first_n;
      busy     <= busy_n;
    end
  end

endmodule
